// File: rtl/interboard_receiver.sv
// Receive engine of the inter-board link: 4-phase Request/Ack, 2-word frames,
// parity/reserved-bit validation and a per-state timeout.
module interboard_receiver #(
  parameter int TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       interboard_rst,
  input  logic       Request_in,
  input  logic [5:0] inter_data_in,
  output logic       Ack_out,
  output logic       interboard_en,
  output logic [2:0] interboard_msg_type,
  output logic [4:0] interboard_number,
  output logic       rx_error
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {IDLE, ACK0, WAIT1, ACK1, FLUSH} state_t;

  state_t          state, state_next;
  logic            req_meta, req_s;
  logic [CW-1:0]   cnt;
  logic [5:0]      w0, w1;
  logic            counting, timeout, frame_ok;
  logic            ack_d, en_d, err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      req_meta <= 1'b0;
      req_s    <= 1'b0;
    end else begin
      req_meta <= Request_in;
      req_s    <= req_meta;
    end
  end

  assign counting = (state == ACK0) || (state == WAIT1) || (state == ACK1);
  assign timeout  = counting && (cnt == CW'(TIMEOUT - 1));
  // Even parity across all 9 payload+parity bits; reserved bits must be zero.
  assign frame_ok = ((^{w0, w1[5:4], w1[0]}) == 1'b0) && (w1[3:1] == 3'b000);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (interboard_rst) begin
      state_next = FLUSH;
    end else if (timeout) begin
      state_next = FLUSH;
    end else begin
      case (state)
        IDLE:    if (req_s)  state_next = ACK0;
        ACK0:    if (!req_s) state_next = WAIT1;
        WAIT1:   if (req_s)  state_next = ACK1;
        ACK1:    if (!req_s) state_next = IDLE;
        FLUSH:   if (!req_s) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    ack_d = (state_next == ACK0) || (state_next == ACK1);
    en_d  = 1'b0;
    err_d = 1'b0;
    if (!interboard_rst) begin
      if (timeout) begin
        err_d = 1'b1;
      end else if (state == ACK1 && !req_s) begin
        en_d  = frame_ok;
        err_d = !frame_ok;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      Ack_out             <= 1'b0;
      interboard_en       <= 1'b0;
      rx_error            <= 1'b0;
      interboard_msg_type <= '0;
      interboard_number   <= '0;
      w0                  <= '0;
      w1                  <= '0;
      cnt                 <= '0;
    end else begin
      Ack_out       <= ack_d;
      interboard_en <= en_d;
      rx_error      <= err_d;
      if (en_d) begin
        interboard_msg_type <= w0[5:3];
        interboard_number   <= {w0[2:0], w1[5:4]};
      end
      if (state == IDLE && state_next == ACK0)  w0 <= inter_data_in;
      if (state == WAIT1 && state_next == ACK1) w1 <= inter_data_in;
      if (state_next != state || !counting) cnt <= '0;
      else                                  cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: doc/interboard_receiver.md
# interboard_receiver

Receive-side engine of the inter-board link. It accepts 2-word frames from the peer board's transmitter over a 4-phase Request/Ack handshake on a 6-bit data bus. It checks parity and reserved bits, then presents the decoded message type and number to GameControl with a one-cycle enable pulse. It sits between the board pins (through the communication top-level muxing) and GameControl.

## Interface
- TIMEOUT, 1000: max cycles the FSM waits in any mid-frame state before aborting the frame.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- interboard_rst  in  1  peer-requested reset (all-ones pattern on the link, decoded upstream). Aborts any frame.
- Request_in  in  1  peer Request, asynchronous to clk.
- inter_data_in  in  6  peer data. Stable from before Request rises until after Ack rises.
- Ack_out  out  1  acknowledge to peer, registered.
- interboard_en  out  1  one-cycle pulse: a valid frame was received.
- interboard_msg_type  out  3  decoded message type. Holds its last valid value.
- interboard_number  out  5  decoded number. Holds its last valid value.
- rx_error  out  1  one-cycle pulse on a parity or reserved-bit error, or on a timeout.

## Operation
- Request_in passes through a 2-flop synchronizer; the FSM uses only the synchronized signal req_s. Data is sampled directly, since it is protocol-stable by then.
- Frame format, sent MSB first:
  - w0 = {msg_type[2:0], number[4:2]}
  - w1 = {number[1:0], 3'b000, p}, where p = XOR of the 8 payload bits (even parity over the 9 bits).
- States:
  - IDLE: Ack_out=0. When req_s=1, capture w0 and go to ACK0.
  - ACK0: Ack_out=1. When req_s=0, go to WAIT1.
  - WAIT1: Ack_out=0. When req_s=1, capture w1 and go to ACK1.
  - ACK1: Ack_out=1. When req_s=0, go to IDLE and validate the frame.
  - FLUSH: Ack_out=0. When req_s=0, go to IDLE. Prevents re-capturing a stale Request.
- Validation happens on the ACK1→IDLE edge:
  - Parity OK and w1[3:1]==0: register msg_type and number, pulse interboard_en.
  - Otherwise: pulse rx_error. Outputs keep their previous values.
- Timeout:
  - A cycle counter clears on every state change and counts in ACK0, WAIT1 and ACK1.
  - When it reaches TIMEOUT-1, go to FLUSH and pulse rx_error. No interboard_en.
- interboard_rst (not rst): from any state, go to FLUSH on the next edge. Ack_out=0, counter cleared, no pulses, data outputs kept.
- rst: synchronizer flops, state (IDLE), counter, captured words and all outputs clear to 0.
- Precedence: rst > interboard_rst > timeout > normal transitions.
- Counter width is clog2(TIMEOUT). TIMEOUT must be ≥ 2.

## Timing
- Reset values: Ack_out=0, interboard_en=0, rx_error=0, interboard_msg_type=0, interboard_number=0. State is IDLE.
- Request_in first high at edge N: req_s is high after edge N+1. The capture and the IDLE→ACK0 transition occur at edge N+2, so Ack_out is high from edge N+2.
- The same 2-cycle synchronizer latency applies to every Request edge. Ack_out changes exactly one edge after the FSM sees the corresponding req_s level.
- interboard_en and rx_error are high for exactly the one cycle following the ACK1→IDLE edge (or the timeout edge). They are never both high.
- Data outputs change on the same edge interboard_en rises.
- Minimum frame length with an immediate-responding sender: about 12 cycles. Back-to-back frames are accepted with no idle gap beyond the handshake.
- Request already high when leaving FLUSH is impossible, because FLUSH exits only on req_s=0.

## Test plan
- Valid frame: msg_type=3'b010, number=5'd17, sent as w0=6'b010100, w1=6'b010001 with a well-behaved handshake.
  - Required: Ack_out rises 2 cycles after each Request rise.
  - Required: one interboard_en pulse, interboard_msg_type=2, interboard_number=17, rx_error never asserted.
- Parity error: same frame with w1=6'b010000.
  - Required: full handshake completes, rx_error pulses once, no interboard_en, outputs keep their prior values (17 and 2).
- Reserved-bit error: w1=6'b010101.
  - Required: rx_error pulse, no interboard_en.
- Timeout: TIMEOUT=16. Send w0, then hold Request high indefinitely.
  - Required: 16 cycles after entering ACK0, Ack_out drops and rx_error pulses.
  - Required: FSM stays in FLUSH until Request falls, and a following valid frame (type 5, number 3) is decoded correctly.
- interboard_rst mid-frame: assert it while in WAIT1, with Request held high.
  - Required: next edge Ack_out=0, no pulses, state FLUSH.
  - Required: after release and Request low, a new valid frame is received.
- Back-to-back frames: send type 1/number 31, then type 7/number 0, with no gap.
  - Required: two interboard_en pulses with the correct values in order, no rx_error.
